// File: rtl/lsq_scheduler.sv
// rtl/lsq_scheduler.sv - in-order load/store queue feeding the data-memory port; optional LSQ_MISALIGN_TRAP_EN adds a misalignment trap
module lsq_scheduler #(
    parameter int P_XLEN  = 32,
    parameter int P_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              resetb_i,
    input  logic              clk_en_i,
    input  logic              ex_lq_wr_i,
    input  logic              ex_sq_wr_i,
    input  logic [2:0]        ex_funct3_i,
    input  logic [4:0]        ex_regd_addr_i,
    input  logic [P_XLEN-1:0] ex_regs2_data_i,
    input  logic [P_XLEN-1:0] ex_addr_i,
    output logic              lsq_full_o,
    input  logic              ex_wb_wr_i,
    input  logic [4:0]        ex_wb_addr_i,
    input  logic [P_XLEN-1:0] ex_wb_data_i,
    output logic              rf_wr_o,
    output logic [4:0]        rf_addr_o,
    output logic [P_XLEN-1:0] rf_data_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [3:0]        dmem_be_o,
    output logic [P_XLEN-1:0] dmem_addr_o,
    output logic [P_XLEN-1:0] dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic              dmem_rvalid_i,
`ifdef LSQ_MISALIGN_TRAP_EN
    output logic              lsq_misalign_o,
    output logic [P_XLEN-1:0] lsq_misalign_addr_o,
`endif
    input  logic [P_XLEN-1:0] dmem_rdata_i
);

    localparam int PW = $clog2(P_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_WB} state_t;

    state_t            state_q, state_nxt;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;

    logic              q_store [P_DEPTH];
    logic [2:0]        q_funct3 [P_DEPTH];
    logic [4:0]        q_regd [P_DEPTH];
    logic [P_XLEN-1:0] q_wdata [P_DEPTH];
    logic [P_XLEN-1:0] q_addr [P_DEPTH];

    logic              h_store;
    logic [2:0]        h_f3;
    logic [4:0]        h_regd;
    logic [P_XLEN-1:0] h_wdata, h_addr;
    logic              h_is_b, h_is_h;
    logic [3:0]        h_be;
    logic [P_XLEN-1:0] h_wd_rep;
    logic [P_XLEN-1:0] rsh_b, rsh_h, ld_ext;

    logic              push, pop, pop_fire, issue;
    logic [4:0]        ld_regd_q;
    logic [P_XLEN-1:0] ld_data_q;

`ifdef LSQ_MISALIGN_TRAP_EN
    logic              h_misalign, trap;
`endif

    assign lsq_full_o = (count_q == CW'(P_DEPTH));
    assign push       = (ex_lq_wr_i | ex_sq_wr_i) & clk_en_i & ~lsq_full_o;
    assign pop_fire   = pop & clk_en_i;

    assign h_store = q_store[rd_ptr_q];
    assign h_f3    = q_funct3[rd_ptr_q];
    assign h_regd  = q_regd[rd_ptr_q];
    assign h_wdata = q_wdata[rd_ptr_q];
    assign h_addr  = q_addr[rd_ptr_q];

    // Unsigned byte/half encodings exist only for loads; for stores they fall back to word.
    assign h_is_b = (h_f3 == 3'b000) | (~h_store & (h_f3 == 3'b100));
    assign h_is_h = (h_f3 == 3'b001) | (~h_store & (h_f3 == 3'b101));

`ifdef LSQ_MISALIGN_TRAP_EN
    assign h_misalign = (h_is_h & h_addr[0]) | (~h_is_b & ~h_is_h & (h_addr[1:0] != 2'b00));
`endif

    // Queue storage; a store wins when both push strobes are raised together.
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_store[wr_ptr_q]  <= ex_sq_wr_i;
            q_funct3[wr_ptr_q] <= ex_funct3_i;
            q_regd[wr_ptr_q]   <= ex_regd_addr_i;
            q_wdata[wr_ptr_q]  <= ex_regs2_data_i;
            q_addr[wr_ptr_q]   <= ex_addr_i;
        end
    end

    // Pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_fire)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Byte enables and lane-replicated write data for the head entry.
    always_comb begin
        h_be     = 4'b1111;
        h_wd_rep = h_wdata;
        if (h_is_b) begin
            h_be     = 4'b0001 << h_addr[1:0];
            h_wd_rep = {(P_XLEN/8){h_wdata[7:0]}};
        end else if (h_is_h) begin
            h_be     = 4'b0011 << {h_addr[1], 1'b0};
            h_wd_rep = {(P_XLEN/16){h_wdata[15:0]}};
        end
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        rsh_b  = dmem_rdata_i >> {h_addr[1:0], 3'b000};
        rsh_h  = dmem_rdata_i >> {h_addr[1], 4'b0000};
        ld_ext = dmem_rdata_i;
        if (h_is_b)
            ld_ext = {{(P_XLEN-8){~h_f3[2] & rsh_b[7]}}, rsh_b[7:0]};
        else if (h_is_h)
            ld_ext = {{(P_XLEN-16){~h_f3[2] & rsh_h[15]}}, rsh_h[15:0]};
    end

    // FSM state register; a low clock enable freezes it.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i)
            state_q <= S_IDLE;
        else if (clk_en_i)
            state_q <= state_nxt;
    end

    // FSM next state plus issue/pop strobes.
    always_comb begin
        state_nxt = state_q;
        pop       = 1'b0;
        issue     = 1'b0;
`ifdef LSQ_MISALIGN_TRAP_EN
        trap      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
`ifdef LSQ_MISALIGN_TRAP_EN
                    if (h_misalign) begin
                        trap = 1'b1;
                        pop  = 1'b1;
                    end else begin
                        issue     = 1'b1;
                        state_nxt = S_REQ;
                    end
`else
                    issue     = 1'b1;
                    state_nxt = S_REQ;
`endif
                end
            end
            S_REQ: begin
                if (dmem_ack_i) begin
                    if (h_store) begin
                        pop       = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (dmem_rvalid_i) begin
                    pop       = 1'b1;
                    state_nxt = (h_regd != 5'd0) ? S_WB : S_IDLE;
                end
            end
            S_WB: begin
                if (!ex_wb_wr_i)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Memory request registers: loaded on issue, request dropped on ack.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_be_o    <= 4'b0000;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
        end else if (clk_en_i) begin
            if (issue) begin
                dmem_req_o   <= 1'b1;
                dmem_we_o    <= h_store;
                dmem_be_o    <= h_be;
                dmem_addr_o  <= {h_addr[P_XLEN-1:2], 2'b00};
                dmem_wdata_o <= h_wd_rep;
            end else if ((state_q == S_REQ) && dmem_ack_i) begin
                dmem_req_o <= 1'b0;
            end
        end
    end

    // Capture the extended load result and its destination when data returns.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            ld_regd_q <= 5'd0;
            ld_data_q <= '0;
        end else if (clk_en_i && (state_q == S_RESP) && dmem_rvalid_i) begin
            ld_regd_q <= h_regd;
            ld_data_q <= ld_ext;
        end
    end

`ifdef LSQ_MISALIGN_TRAP_EN
    // One-cycle trap pulse with the offending address held until the next trap.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            lsq_misalign_o      <= 1'b0;
            lsq_misalign_addr_o <= '0;
        end else if (clk_en_i) begin
            lsq_misalign_o <= trap;
            if (trap)
                lsq_misalign_addr_o <= h_addr;
        end
    end
`endif

    // Shared regfile port: ex_stage write-back always wins over the load.
    always_comb begin
        rf_wr_o   = (state_q == S_WB);
        rf_addr_o = ld_regd_q;
        rf_data_o = ld_data_q;
        if (ex_wb_wr_i) begin
            rf_wr_o   = 1'b1;
            rf_addr_o = ex_wb_addr_i;
            rf_data_o = ex_wb_data_i;
        end
    end

endmodule

// File: tb/tb_lsq_scheduler.sv
// tb/tb_lsq_scheduler.sv - directed self-checking bench for lsq_scheduler
module tb_lsq_scheduler;

    logic        clk_i = 1'b0;
    logic        resetb_i;
    logic        clk_en_i;
    logic        ex_lq_wr_i;
    logic        ex_sq_wr_i;
    logic [2:0]  ex_funct3_i;
    logic [4:0]  ex_regd_addr_i;
    logic [31:0] ex_regs2_data_i;
    logic [31:0] ex_addr_i;
    logic        lsq_full_o;
    logic        ex_wb_wr_i;
    logic [4:0]  ex_wb_addr_i;
    logic [31:0] ex_wb_data_i;
    logic        rf_wr_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
`ifdef LSQ_MISALIGN_TRAP_EN
    logic        lsq_misalign_o;
    logic [31:0] lsq_misalign_addr_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    lsq_scheduler #(.P_XLEN(32), .P_DEPTH(4)) dut (
        .clk_i           (clk_i),
        .resetb_i        (resetb_i),
        .clk_en_i        (clk_en_i),
        .ex_lq_wr_i      (ex_lq_wr_i),
        .ex_sq_wr_i      (ex_sq_wr_i),
        .ex_funct3_i     (ex_funct3_i),
        .ex_regd_addr_i  (ex_regd_addr_i),
        .ex_regs2_data_i (ex_regs2_data_i),
        .ex_addr_i       (ex_addr_i),
        .lsq_full_o      (lsq_full_o),
        .ex_wb_wr_i      (ex_wb_wr_i),
        .ex_wb_addr_i    (ex_wb_addr_i),
        .ex_wb_data_i    (ex_wb_data_i),
        .rf_wr_o         (rf_wr_o),
        .rf_addr_o       (rf_addr_o),
        .rf_data_o       (rf_data_o),
        .dmem_req_o      (dmem_req_o),
        .dmem_we_o       (dmem_we_o),
        .dmem_be_o       (dmem_be_o),
        .dmem_addr_o     (dmem_addr_o),
        .dmem_wdata_o    (dmem_wdata_o),
        .dmem_ack_i      (dmem_ack_i),
        .dmem_rvalid_i   (dmem_rvalid_i),
`ifdef LSQ_MISALIGN_TRAP_EN
        .lsq_misalign_o      (lsq_misalign_o),
        .lsq_misalign_addr_o (lsq_misalign_addr_o),
`endif
        .dmem_rdata_i    (dmem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_op(input logic st, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] wd, input logic [31:0] a);
        ex_lq_wr_i      = ~st;
        ex_sq_wr_i      = st;
        ex_funct3_i     = f3;
        ex_regd_addr_i  = rd;
        ex_regs2_data_i = wd;
        ex_addr_i       = a;
        tick();
        ex_lq_wr_i = 1'b0;
        ex_sq_wr_i = 1'b0;
    endtask

    task automatic serve(input string tag, input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
        int t = 0;
        while (!dmem_req_o && t < 20) begin
            tick();
            t++;
        end
        chk({tag, "_req"}, 32'(dmem_req_o), 32'd1);
        chk({tag, "_we"}, 32'(dmem_we_o), 32'(we));
        chk({tag, "_be"}, 32'(dmem_be_o), 32'(be));
        chk({tag, "_addr"}, dmem_addr_o, a);
        if (we)
            chk({tag, "_wdata"}, dmem_wdata_o, wd);
        dmem_ack_i = 1'b1;
        tick();
        dmem_ack_i = 1'b0;
        if (!we) begin
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = rd;
            tick();
            dmem_rvalid_i = 1'b0;
            dmem_rdata_i  = 32'h0;
        end
    endtask

    task automatic expect_wb(input string tag, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, "_rfwr"}, 32'(rf_wr_o), 32'd1);
        chk({tag, "_rfaddr"}, 32'(rf_addr_o), 32'(rd));
        chk({tag, "_rfdata"}, rf_data_o, d);
        tick();
        chk({tag, "_rfdone"}, 32'(rf_wr_o), 32'd0);
    endtask

    initial begin
        resetb_i = 1'b0; clk_en_i = 1'b1;
        ex_lq_wr_i = 1'b0; ex_sq_wr_i = 1'b0; ex_funct3_i = 3'd0; ex_regd_addr_i = 5'd0;
        ex_regs2_data_i = 32'h0; ex_addr_i = 32'h0;
        ex_wb_wr_i = 1'b0; ex_wb_addr_i = 5'd0; ex_wb_data_i = 32'h0;
        dmem_ack_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
        tick();
        tick();
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_we", 32'(dmem_we_o), 32'd0);
        chk("rst_be", 32'(dmem_be_o), 32'd0);
        chk("rst_addr", dmem_addr_o, 32'h0);
        chk("rst_wdata", dmem_wdata_o, 32'h0);
        chk("rst_rfwr", 32'(rf_wr_o), 32'd0);
        chk("rst_full", 32'(lsq_full_o), 32'd0);
        resetb_i = 1'b1;
        tick();

        // 1: SW with latency, clock-enable freeze and pop on ack
        push_op(1'b1, 3'b010, 5'd0, 32'hDEADBEEF, 32'h100);
        chk("t1_lat_n1", 32'(dmem_req_o), 32'd0);
        tick();
        chk("t1_lat_n2", 32'(dmem_req_o), 32'd1);
        chk("t1_we", 32'(dmem_we_o), 32'd1);
        chk("t1_be", 32'(dmem_be_o), 32'hF);
        chk("t1_addr", dmem_addr_o, 32'h100);
        chk("t1_wdata", dmem_wdata_o, 32'hDEADBEEF);
        clk_en_i = 1'b0;
        dmem_ack_i = 1'b1;
        tick();
        chk("t1_frozen", 32'(dmem_req_o), 32'd1);
        clk_en_i = 1'b1;
        tick();
        dmem_ack_i = 1'b0;
        chk("t1_ackdrop", 32'(dmem_req_o), 32'd0);
        tick();
        chk("t1_popped", 32'(dmem_req_o), 32'd0);

        // 2: LB / LBU from the top byte lane
        push_op(1'b0, 3'b000, 5'd5, 32'h0, 32'h103);
        serve("t2_lb", 1'b0, 4'b1000, 32'h100, 32'h0, 32'h80123456);
        expect_wb("t2_lb", 5'd5, 32'hFFFFFF80);
        push_op(1'b0, 3'b100, 5'd5, 32'h0, 32'h103);
        serve("t2_lbu", 1'b0, 4'b1000, 32'h100, 32'h0, 32'h80123456);
        expect_wb("t2_lbu", 5'd5, 32'h00000080);

        // 3: fill the queue while memory stalls, drop the fifth push, drain in order
        push_op(1'b1, 3'b010, 5'd0, 32'h11111111, 32'h200);
        push_op(1'b1, 3'b000, 5'd0, 32'h000000AB, 32'h201);
        push_op(1'b1, 3'b001, 5'd0, 32'h0000CDEF, 32'h206);
        push_op(1'b0, 3'b001, 5'd7, 32'h0, 32'h20A);
        chk("t3_full", 32'(lsq_full_o), 32'd1);
        push_op(1'b1, 3'b010, 5'd0, 32'h55555555, 32'h300);
        chk("t3_full_drop", 32'(lsq_full_o), 32'd1);
        serve("t3_sw", 1'b1, 4'b1111, 32'h200, 32'h11111111, 32'h0);
        chk("t3_notfull", 32'(lsq_full_o), 32'd0);
        serve("t3_sb", 1'b1, 4'b0010, 32'h200, 32'hABABABAB, 32'h0);
        serve("t3_sh", 1'b1, 4'b1100, 32'h204, 32'hCDEFCDEF, 32'h0);
        serve("t3_lh", 1'b0, 4'b1100, 32'h208, 32'h0, 32'h80017FFF);
        expect_wb("t3_lh", 5'd7, 32'hFFFF8001);
        for (int i = 0; i < 4; i++) tick();
        chk("t3_noextra", 32'(dmem_req_o), 32'd0);

        // 4: ex_stage write-back priority over a pending load
        push_op(1'b0, 3'b010, 5'd9, 32'h0, 32'h400);
        serve("t4_lw", 1'b0, 4'b1111, 32'h400, 32'h0, 32'h12345678);
        for (int i = 0; i < 3; i++) begin
            ex_wb_wr_i   = 1'b1;
            ex_wb_addr_i = 5'd3;
            ex_wb_data_i = 32'hA0 + 32'(i);
            #1;
            chk("t4_ex_wr", 32'(rf_wr_o), 32'd1);
            chk("t4_ex_addr", 32'(rf_addr_o), 32'd3);
            chk("t4_ex_data", rf_data_o, 32'hA0 + 32'(i));
            tick();
        end
        ex_wb_wr_i = 1'b0;
        #1;
        expect_wb("t4_ld", 5'd9, 32'h12345678);

        // load to x0 returns straight to idle without a write
        push_op(1'b0, 3'b010, 5'd0, 32'h0, 32'h600);
        serve("t4_x0", 1'b0, 4'b1111, 32'h600, 32'h0, 32'hFFFFFFFF);
        chk("t4_x0_nowr", 32'(rf_wr_o), 32'd0);

        // 5: asynchronous reset during REQ abandons the op and empties the queue
        push_op(1'b1, 3'b010, 5'd0, 32'h1, 32'h500);
        push_op(1'b1, 3'b010, 5'd0, 32'h2, 32'h504);
        chk("t5_inreq", 32'(dmem_req_o), 32'd1);
        #2;
        resetb_i = 1'b0;
        #1;
        chk("t5_req0", 32'(dmem_req_o), 32'd0);
        chk("t5_full0", 32'(lsq_full_o), 32'd0);
        chk("t5_addr0", dmem_addr_o, 32'h0);
        tick();
        resetb_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("t5_empty", 32'(dmem_req_o), 32'd0);

        // 6: misaligned word load
        push_op(1'b0, 3'b010, 5'd4, 32'h0, 32'h102);
`ifdef LSQ_MISALIGN_TRAP_EN
        chk("t6_noreq_a", 32'(dmem_req_o), 32'd0);
        tick();
        chk("t6_pulse", 32'(lsq_misalign_o), 32'd1);
        chk("t6_maddr", lsq_misalign_addr_o, 32'h102);
        chk("t6_noreq_b", 32'(dmem_req_o), 32'd0);
        tick();
        chk("t6_pulse_end", 32'(lsq_misalign_o), 32'd0);
        tick();
        chk("t6_noreq_c", 32'(dmem_req_o), 32'd0);
`else
        serve("t6_lw", 1'b0, 4'b1111, 32'h100, 32'h0, 32'hCAFEF00D);
        expect_wb("t6_lw", 5'd4, 32'hCAFEF00D);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
